// File: rtl/video_pkg.sv
// Shared video constants and types for the sprite path.
//   COORD_W            : scan coordinate width
//   SPRITE_W/SPRITE_H  : default sprite size in pixels
//   KEY_COLOUR         : default transparent colour key
//   pos_t              : packed (x, y) sprite position
//   upd_state_t        : position update FSM states
package video_pkg;

    localparam int          COORD_W    = 10;
    localparam int          SPRITE_W   = 8;
    localparam int          SPRITE_H   = 16;
    localparam logic [23:0] KEY_COLOUR = 24'h000000;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;

    typedef enum logic {
        UPD_EMPTY   = 1'b0,
        UPD_PENDING = 1'b1
    } upd_state_t;

endpackage

// File: rtl/sprite_pos_latch.sv
// Double-buffered sprite position. A new position is accepted through a
// valid/ready handshake into a pending slot and only becomes active on
// frame_start, so a frame is never rendered with two positions.
//   clock, reset_n        : clock, async active-low reset
//   frame_start           : frame boundary pulse
//   pos_valid/pos_x/pos_y : offered position
//   pos_ready             : slot free (EMPTY state)
//   active                : position used by the renderer
module sprite_pos_latch
    import video_pkg::*;
#(
    parameter coord_t INIT_X = '0,
    parameter coord_t INIT_Y = '0
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   frame_start,
    input  logic   pos_valid,
    input  coord_t pos_x,
    input  coord_t pos_y,
    output logic   pos_ready,
    output pos_t   active
);

    upd_state_t state_q, state_d;
    pos_t       pend_q, pend_d;
    pos_t       act_d;
    logic       xfer;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UPD_EMPTY;
            pend_q  <= '0;
            active  <= '{x: INIT_X, y: INIT_Y};
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            active  <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        act_d     = active;
        pos_ready = (state_q == UPD_EMPTY);
        xfer      = pos_valid && pos_ready;
        case (state_q)
            UPD_EMPTY: begin
                if (xfer && frame_start) begin
                    // Frame boundary coincides with the offer: skip the
                    // pending slot and go live immediately.
                    act_d = '{x: pos_x, y: pos_y};
                end else if (xfer) begin
                    pend_d  = '{x: pos_x, y: pos_y};
                    state_d = UPD_PENDING;
                end
            end
            UPD_PENDING: begin
                if (frame_start) begin
                    act_d   = pend_q;
                    state_d = UPD_EMPTY;
                end
            end
            default: state_d = UPD_EMPTY;
        endcase
    end

endmodule

// File: rtl/sprite_renderer.sv
// Single-sprite overlay on a scan stream. Two-stage pipeline, one pixel per
// cycle, no stalls:
//   stage 1 : sprite window test, bitmap offset (xofs/yofs), bg delay
//   stage 2 : colour-key test against the external bitmap colour, mux
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   frame_start                    : frame boundary pulse
//   pix_valid/pix_x/pix_y/bg_colour: scan pixel in
//   pos_valid/pos_x/pos_y/pos_ready: sprite position handshake
//   xofs/yofs                      : bitmap lookup address (registered)
//   sprite_rgb                     : bitmap colour for xofs/yofs (comb)
//   out_valid/out_colour/out_hit   : composited pixel out
module sprite_renderer
    import video_pkg::COORD_W, video_pkg::coord_t, video_pkg::pos_t;
#(
    parameter int          SPRITE_W   = video_pkg::SPRITE_W,
    parameter int          SPRITE_H   = video_pkg::SPRITE_H,
    parameter logic [23:0] KEY_COLOUR = video_pkg::KEY_COLOUR,
    parameter coord_t      INIT_X     = '0,
    parameter coord_t      INIT_Y     = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [23:0]        bg_colour,
    input  logic               pos_valid,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               pos_ready,
    output logic [15:0]        xofs,
    output logic [15:0]        yofs,
    input  logic [23:0]        sprite_rgb,
    output logic               out_valid,
    output logic [23:0]        out_colour,
    output logic               out_hit
);

    // Sprite extents widened by one bit so the window end never wraps;
    // a sprite hanging off the right/bottom edge is simply clipped.
    localparam logic [COORD_W:0] W_EXT = SPRITE_W[COORD_W:0];
    localparam logic [COORD_W:0] H_EXT = SPRITE_H[COORD_W:0];

    pos_t act;

    sprite_pos_latch #(
        .INIT_X (INIT_X),
        .INIT_Y (INIT_Y)
    ) u_pos (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pos_valid   (pos_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_ready   (pos_ready),
        .active      (act)
    );

    // ---------------- stage 1 ----------------
    logic [COORD_W:0]   sx_end, sy_end;
    logic [COORD_W-1:0] dx, dy;
    logic               hit_c;

    always_comb begin
        sx_end = {1'b0, act.x} + W_EXT;
        sy_end = {1'b0, act.y} + H_EXT;
        hit_c  = pix_valid
              && (pix_x >= act.x) && ({1'b0, pix_x} < sx_end)
              && (pix_y >= act.y) && ({1'b0, pix_y} < sy_end);
        dx     = pix_x - act.x;
        dy     = pix_y - act.y;
    end

    logic [2:1]  vld_pipe;
    logic        hit1;
    logic [23:0] bg1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            hit1     <= 1'b0;
            bg1      <= '0;
            xofs     <= '0;
            yofs     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], pix_valid};
            hit1     <= hit_c;
            bg1      <= bg_colour;
            xofs     <= hit_c ? {{(16-COORD_W){1'b0}}, dx} : 16'd0;
            yofs     <= hit_c ? {{(16-COORD_W){1'b0}}, dy} : 16'd0;
        end
    end

    // ---------------- stage 2 ----------------
    logic opaque;
    assign opaque = hit1 && (sprite_rgb != KEY_COLOUR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_hit    <= 1'b0;
            out_colour <= '0;
        end else begin
            out_hit    <= opaque;
            // Idle slots output black rather than a stale background.
            out_colour <= !vld_pipe[1] ? 24'd0 : (opaque ? sprite_rgb : bg1);
        end
    end

    assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_sprite_renderer.sv
module tb_sprite_renderer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] bg_colour;
    logic        pos_valid;
    logic [9:0]  pos_x, pos_y;
    logic        pos_ready;
    logic [15:0] xofs, yofs;
    logic [23:0] sprite_rgb;
    logic        out_valid;
    logic [23:0] out_colour;
    logic        out_hit;

    int errors = 0;
    int checks = 0;

    logic [15:0] s1_xofs, s1_yofs;
    logic        o_valid, o_hit;
    logic [23:0] o_col;

    sprite_renderer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bg_colour   (bg_colour),
        .pos_valid   (pos_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_ready   (pos_ready),
        .xofs        (xofs),
        .yofs        (yofs),
        .sprite_rgb  (sprite_rgb),
        .out_valid   (out_valid),
        .out_colour  (out_colour),
        .out_hit     (out_hit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $error("FAIL timeout: wait expired before test completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic pix(input logic v, input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] bg, input logic [23:0] rgb, input logic fs);
        pix_valid   = v;
        pix_x       = x;
        pix_y       = y;
        bg_colour   = bg;
        frame_start = fs;
        @(posedge clock); #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        s1_xofs     = xofs;
        s1_yofs     = yofs;
        sprite_rgb  = rgb;
        @(posedge clock); #1;
        o_valid     = out_valid;
        o_hit       = out_hit;
        o_col       = out_colour;
    endtask

    task automatic offer(input logic [9:0] x, input logic [9:0] y, input logic fs);
        pos_valid   = 1'b1;
        pos_x       = x;
        pos_y       = y;
        frame_start = fs;
        @(posedge clock); #1;
        pos_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
        bg_colour = 0; pos_valid = 0; pos_x = 0; pos_y = 0; sprite_rgb = 0;
        #22;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_colour", out_colour, 24'h0);
        chk("rst_pos_ready", pos_ready, 1'b1);
        chk("rst_xofs", xofs, 16'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        offer(10'd100, 10'd50, 1'b1);
        chk("same_cycle_ready", pos_ready, 1'b1);

        pix(1, 10'd103, 10'd55, 24'h111111, 24'hFF00FF, 0);
        chk("hit_xofs", s1_xofs, 16'd3);
        chk("hit_yofs", s1_yofs, 16'd5);
        chk("hit_valid", o_valid, 1'b1);
        chk("hit_hit", o_hit, 1'b1);
        chk("hit_colour", o_col, 24'hFF00FF);

        pix(1, 10'd108, 10'd55, 24'hABCDEF, 24'hFF00FF, 0);
        chk("right_edge_hit", o_hit, 1'b0);
        chk("right_edge_colour", o_col, 24'hABCDEF);
        chk("right_edge_xofs", s1_xofs, 16'd0);

        pix(1, 10'd99, 10'd50, 24'h222222, 24'hFF00FF, 0);
        chk("left_edge_hit", o_hit, 1'b0);

        pix(1, 10'd107, 10'd65, 24'h333333, 24'h00FF00, 0);
        chk("corner_xofs", s1_xofs, 16'd7);
        chk("corner_yofs", s1_yofs, 16'd15);
        chk("corner_colour", o_col, 24'h00FF00);

        pix(1, 10'd100, 10'd66, 24'h444444, 24'h00FF00, 0);
        chk("bottom_edge_hit", o_hit, 1'b0);

        pix(1, 10'd104, 10'd60, 24'h123456, 24'h000000, 0);
        chk("key_xofs", s1_xofs, 16'd4);
        chk("key_hit", o_hit, 1'b0);
        chk("key_colour", o_col, 24'h123456);

        pix(0, 10'd103, 10'd55, 24'h777777, 24'hFF00FF, 0);
        chk("idle_valid", o_valid, 1'b0);
        chk("idle_hit", o_hit, 1'b0);
        chk("idle_colour", o_col, 24'h0);

        offer(10'd200, 10'd200, 1'b0);
        chk("pending_ready", pos_ready, 1'b0);
        pix(1, 10'd103, 10'd55, 24'h111111, 24'hFF00FF, 0);
        chk("pending_old_hit", o_hit, 1'b1);
        pix(1, 10'd203, 10'd205, 24'h111111, 24'hFF00FF, 0);
        chk("pending_new_miss", o_hit, 1'b0);
        fs_pulse();
        chk("commit_ready", pos_ready, 1'b1);
        pix(1, 10'd203, 10'd205, 24'h111111, 24'hFF00FF, 0);
        chk("commit_new_hit", o_hit, 1'b1);
        chk("commit_xofs", s1_xofs, 16'd3);
        chk("commit_yofs", s1_yofs, 16'd5);
        pix(1, 10'd103, 10'd55, 24'h555555, 24'hFF00FF, 0);
        chk("commit_old_miss", o_col, 24'h555555);

        offer(10'd10, 10'd20, 1'b1);
        chk("same_cycle_ready2", pos_ready, 1'b1);
        pix(1, 10'd10, 10'd20, 24'h0, 24'hC0FFEE, 0);
        chk("same_cycle_hit", o_col, 24'hC0FFEE);

        offer(10'd1020, 10'd470, 1'b1);
        pix(1, 10'd1023, 10'd470, 24'h0, 24'hFF00FF, 0);
        chk("clip_xofs", s1_xofs, 16'd3);
        chk("clip_hit", o_hit, 1'b1);
        pix(1, 10'd2, 10'd470, 24'h666666, 24'hFF00FF, 0);
        chk("clip_alias_hit", o_hit, 1'b0);
        chk("clip_alias_colour", o_col, 24'h666666);

        offer(10'd300, 10'd300, 1'b0);
        pix(1, 10'd1023, 10'd470, 24'h0, 24'hFF00FF, 1);
        chk("inflight_old_hit", o_hit, 1'b1);
        chk("inflight_ready", pos_ready, 1'b1);
        pix(1, 10'd301, 10'd301, 24'h0, 24'hFF00FF, 0);
        chk("inflight_new_hit", o_hit, 1'b1);

        offer(10'd500, 10'd500, 1'b0);
        pix_valid = 1; pix_x = 10'd301; pix_y = 10'd301;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("pre_reset_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_pos_ready", pos_ready, 1'b1);
        chk("async_xofs", xofs, 16'h0);
        pix_valid = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        pix(1, 10'd3, 10'd4, 24'h0, 24'hFF00FF, 0);
        chk("init_pos_xofs", s1_xofs, 16'd3);
        chk("init_pos_yofs", s1_yofs, 16'd4);
        chk("init_pos_hit", o_hit, 1'b1);
        fs_pulse();
        pix(1, 10'd503, 10'd503, 24'h0, 24'hFF00FF, 0);
        chk("discarded_pending", o_hit, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
